// File: rtl/alu_pkg.sv
// Shared ALU-cluster definitions: default datapath width, multiplier FSM
// states and the radix-2 Booth step operation with its decoder.
package alu_pkg;

  localparam int unsigned WidthDefault = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_e;

  // Radix-2 Booth recoding of {Q[0], q_1}: 01 adds M, 10 subtracts M.
  function automatic booth_op_e booth_decode(input logic [1:0] sel);
    booth_op_e op;
    case (sel)
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// Combinational Booth add/sub step: produces the next accumulator value
// before the arithmetic shift. Subtract is add of ~M with carry-in 1.
module booth_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic [WIDTH:0] areg_i,
  input  logic [WIDTH:0] m_i,
  input  logic [1:0]     sel_i,
  output logic [WIDTH:0] areg_o
);

  localparam int unsigned AccW = WIDTH + 1;

  booth_op_e      op;
  logic [WIDTH:0] addend;
  logic           carry_in;

  // Select the adder operand and carry-in from the recoded Booth pair.
  always_comb begin
    op       = booth_decode(sel_i);
    addend   = '0;
    carry_in = 1'b0;
    unique case (op)
      ADD: addend = m_i;
      SUB: begin
        addend   = ~m_i;
        carry_in = 1'b1;
      end
      default: addend = '0;
    endcase
    // Modulo 2^(WIDTH+1); the extra bit keeps -(-2^(WIDTH-1)) from wrapping.
    areg_o = areg_i + addend + AccW'(carry_in);
  end

endmodule

// File: rtl/booth_multiplier.sv
// Multicycle signed radix-2 Booth multiplier: one add/sub-and-shift step per
// clock, WIDTH steps, then a one-cycle DONE that registers the low WIDTH bits
// of the product and pulses data_resultRDY.
// Optional: define BOOTH_OVERFLOW_CHECK_EN to build the signed-overflow
// exception; otherwise data_exception is tied low.
module booth_multiplier
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH:0]   m_q;
  logic [WIDTH:0]   areg_q;
  logic [WIDTH-1:0] qreg_q;
  logic             q1_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;
  logic             busy_q;

  logic [WIDTH:0]   areg_sum;
  logic [WIDTH:0]   areg_d;
  logic [WIDTH-1:0] qreg_d;
  logic             q1_d;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .areg_i (areg_q),
    .m_i    (m_q),
    .sel_i  ({qreg_q[0], q1_q}),
    .areg_o (areg_sum)
  );

  // Arithmetic right shift of {Areg, Qreg, q_1} after the add/sub.
  always_comb begin
    areg_d = {areg_sum[WIDTH], areg_sum[WIDTH:1]};
    qreg_d = {areg_sum[0], qreg_q[WIDTH-1:1]};
    q1_d   = qreg_q[0];
  end

  // FSM, step counter, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      m_q      <= '0;
      areg_q   <= '0;
      qreg_q   <= '0;
      q1_q     <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (ctrl_MULT) begin
        // Start from IDLE, or abort and restart from RUN/DONE.
        m_q     <= {data_operandA[WIDTH-1], data_operandA};
        areg_q  <= '0;
        qreg_q  <= data_operandB;
        q1_q    <= 1'b0;
        cnt_q   <= '0;
        state_q <= RUN;
        busy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: state_q <= IDLE;
          RUN: begin
            areg_q <= areg_d;
            qreg_q <= qreg_d;
            q1_q   <= q1_d;
            cnt_q  <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end
          DONE: begin
            result_q <= qreg_q;
`ifdef BOOTH_OVERFLOW_CHECK_EN
            // Fits iff the upper part is pure sign extension of the result.
            exc_q    <= (areg_q != {(WIDTH + 1){qreg_q[WIDTH-1]}});
`else
            exc_q    <= 1'b0;
`endif
            rdy_q    <= 1'b1;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier at WIDTH=32.
module tb_booth_multiplier;

`ifdef BOOTH_OVERFLOW_CHECK_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int errors = 0;
  int checks = 0;

  booth_multiplier #(
    .WIDTH (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse ctrl_MULT across one rising edge; returns just after that edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    // Operands must be ignored outside the start edge.
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h1357_9BDF;
  endtask

  // Sample n falling edges; index 0 is the first one after the start edge.
  task automatic collect(input int n, output int first_rdy, output int pulses,
                         output int busy_n);
    first_rdy = -1;
    pulses    = 0;
    busy_n    = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        pulses++;
        if (first_rdy < 0) first_rdy = i;
      end
      if (busy === 1'b1) busy_n++;
    end
  endtask

  task automatic mult_test(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_r, input logic exp_e);
    int fr, pc, bc;
    start_op(a, b);
    collect(40, fr, pc, bc);
    check({tag, "_lat"}, 64'(fr), 64'(33));
    check({tag, "_pulses"}, 64'(pc), 64'(1));
    check({tag, "_busy"}, 64'(bc), 64'(32));
    check({tag, "_res"}, 64'(data_result), 64'(exp_r));
    check({tag, "_exc"}, 64'(data_exception), 64'(exp_e));
  endtask

  initial begin
    int fr, pc, bc;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_res", 64'(data_result), 64'(0));
    check("rst_exc", 64'(data_exception), 64'(0));
    check("rst_rdy", 64'(data_resultRDY), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset = 1'b1;

    // Basic multiply, latency and hold.
    mult_test("3x5", 32'd3, 32'd5, 32'd15, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("hold15", 64'(data_result), 64'(15));
    end

    // Mixed signs, both operand orders.
    mult_test("m7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0);
    mult_test("6xm7", 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 1'b0);
    mult_test("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);

    // Positive overflow.
    mult_test("maxx2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, OvfEn);
    // Most-negative corners.
    mult_test("minxm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, OvfEn);
    mult_test("minx1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    // Zero operand still runs the full latency.
    mult_test("0xb", 32'd0, 32'h1234_5678, 32'd0, 1'b0);

    // Abort/restart: second start 10 edges after the first.
    start_op(32'd3, 32'd5);
    collect(9, fr, pc, bc);
    check("abort_early_rdy", 64'(pc), 64'(0));
    start_op(32'd4, 32'd4);
    collect(40, fr, pc, bc);
    check("abort_lat", 64'(fr), 64'(33));
    check("abort_pulses", 64'(pc), 64'(1));
    check("abort_res", 64'(data_result), 64'(16));

    // Reset in mid-run: start edge, then reset during cycle 12.
    start_op(32'd9, 32'd9);
    repeat (11) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mrst_res", 64'(data_result), 64'(0));
    check("mrst_exc", 64'(data_exception), 64'(0));
    check("mrst_rdy", 64'(data_resultRDY), 64'(0));
    check("mrst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    collect(40, fr, pc, bc);
    check("mrst_no_rdy", 64'(pc), 64'(0));
    check("mrst_no_busy", 64'(bc), 64'(0));
    mult_test("9x9", 32'd9, 32'd9, 32'd81, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Multicycle signed radix-2 Booth multiplier in the ALU cluster, beside the ripple/lookahead adder slices.
- Accepts two WIDTH-bit two's-complement operands on a start pulse and iterates one add/sub-and-shift step per clock.
- Returns the low WIDTH bits of the product, a ready pulse, and an overflow exception.
- Feeds the writeback mux alongside the ALU adder result; the CPU stall logic consumes data_resultRDY.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 4 to 64.

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- ctrl_MULT  input  1  start pulse; operands sampled on the same edge
- data_operandA  input  WIDTH  multiplicand M, signed
- data_operandB  input  WIDTH  multiplier Q, signed
- data_result  output  WIDTH  low WIDTH bits of A*B, registered
- data_exception  output  1  product does not fit in WIDTH signed bits
- data_resultRDY  output  1  one-cycle pulse, result valid
- busy  output  1  high while iterating

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, step count=0, product register=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- Datapath registers:
  - M: WIDTH+1 bits, sign-extended.
  - P: {Areg (WIDTH+1 bits), Qreg (WIDTH bits), q_1 (1 bit)}.
  - Cnt: clog2(WIDTH+1) bits.
- State IDLE. On ctrl_MULT=1:
  - Load M=sext(A), Areg=0, Qreg=B, q_1=0, Cnt=0.
  - Go to RUN; busy=1 from the next cycle.
- State RUN, one step per clock, selected by {Qreg[0], q_1}:
  - 01: Areg += M.
  - 10: Areg -= M (add ~M with carry-in 1).
  - 00 or 11: Areg unchanged.
  - Then arithmetic right shift of the whole P by 1, replicating Areg MSB.
  - Cnt += 1. When Cnt reaches WIDTH-1 at the edge, go to DONE.
- Arithmetic: Areg is WIDTH+1 bits, so subtracting M=-2^(WIDTH-1) cannot wrap. All adds are modulo 2^(WIDTH+1).
- State DONE, one cycle:
  - Register data_result = Qreg.
  - Register data_exception = 1 iff Areg is not all copies of Qreg[WIDTH-1].
  - data_resultRDY=1 and busy=0 in this cycle. Return to IDLE.
- Latency: ctrl_MULT at edge 0 → data_resultRDY high during the cycle after edge WIDTH+1 (33 cycles for WIDTH=32).
- data_result and data_exception hold their values until the next DONE or reset.
- ctrl_MULT in RUN or DONE aborts the current operation: reload operands, Cnt=0, stay in or enter RUN. No data_resultRDY is issued for the aborted operation.
- Operand inputs are ignored except on a ctrl_MULT edge.
- Reset asserted mid-operation: immediate return to reset values; no pulse on release.
- An operand of 0 still takes the full latency; there is no early termination.

Optional Feature:
- Macro: BOOTH_OVERFLOW_CHECK_EN.
- Defined: data_exception is computed as described in Behaviour.
- Undefined: data_exception is tied to 0 and no overflow comparison logic is built; everything else is identical.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH default constant.
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Booth op typedef: NOP, ADD, SUB.
- Sub-module booth_step: combinational.
  - Inputs: Areg, M, {Qreg[0], q_1}.
  - Output: next Areg before the shift.
  - Built on the team's existing adder slices with a carry-in for subtract.
- The top holds the FSM, counter and registers.

Test Plan:
- Basic multiply, latency and hold: A=3, B=5, ctrl_MULT 1 cycle.
  - data_resultRDY pulses exactly 33 cycles after the start edge; data_result=15, data_exception=0; busy high for 32 cycles.
  - Result stays at 15 for 10 idle cycles.
- Mixed signs: A=-7 (0xFFFFFFF9), B=6 → data_result=0xFFFFFFD6 (-42), data_exception=0. Repeat with operands swapped: same result.
- Positive overflow: A=0x7FFFFFFF, B=2 → data_result=0xFFFFFFFE, data_exception=1. Without BOOTH_OVERFLOW_CHECK_EN: data_exception=0.
- Most-negative corner: A=0x80000000, B=0xFFFFFFFF (-1) → data_result=0x80000000, data_exception=1. Then A=0x80000000, B=1 → data_result=0x80000000, data_exception=0.
- Abort/restart: start 3*5, reassert ctrl_MULT 10 cycles later with 4*4.
  - Exactly one data_resultRDY, 33 cycles after the second start, with data_result=16.
- Reset mid-run: start 9*9, deassert reset (drive 0) at cycle 12.
  - All outputs 0 immediately.
  - No data_resultRDY within 40 cycles after release.
  - A fresh 9*9 then yields 81.
